// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 101 sequence detector.
// Words arrive over valid/ready into a one-word hold buffer. They are then
// shifted out one bit per clock on w. pause inserts idle bits without losing
// data.
//
// state | meaning
// IDLE  | shifter empty (rem == 0); may reload from hold
// SHIFT | shifter still has rem data bits to emit
module seq_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             pause,
  output logic             w,
  output logic             w_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shifter;
  logic [CW-1:0]    rem;
  logic [0:0]       state;

  logic             unload;
  logic             load;
  logic             shift_bit;
  logic [WIDTH-1:0] shift_next;
  logic             hold_bit;
  logic [WIDTH-1:0] hold_next;

  // FSM state is a direct view of whether the shifter still holds bits
  assign state = (rem != '0) ? SHIFT : IDLE;

  // unload never depends on din_valid, so din_ready has no combinational loop
  assign unload    = !pause && (rem == '0) && hold_full;
  assign din_ready = !Reset && (!hold_full || unload);
  assign load      = din_valid && din_ready;
  assign busy      = hold_full || (rem != '0);

  // Select the outgoing bit and the shifted remainder for the shifter and for a fresh hold word
  always_comb begin
    shift_bit  = 1'b0;
    shift_next = '0;
    hold_bit   = 1'b0;
    hold_next  = '0;
    if (MSB_FIRST) begin
      shift_bit  = shifter[WIDTH-1];
      shift_next = {shifter[WIDTH-2:0], 1'b0};
      hold_bit   = hold[WIDTH-1];
      hold_next  = {hold[WIDTH-2:0], 1'b0};
    end else begin
      shift_bit  = shifter[0];
      shift_next = {1'b0, shifter[WIDTH-1:1]};
      hold_bit   = hold[0];
      hold_next  = {1'b0, hold[WIDTH-1:1]};
    end
  end

  // Hold buffer: a same-edge load and unload leaves it full with the new word
  always_ff @(posedge clk) begin
    if (Reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load) begin
        hold <= din;
      end
      if (load) begin
        hold_full <= 1'b1;
      end else if (unload) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Shifter and registered serial outputs; pause has priority and freezes all data state
  always_ff @(posedge clk) begin
    if (Reset) begin
      shifter <= '0;
      rem     <= '0;
      w       <= IDLE_BIT;
      w_valid <= 1'b0;
      last    <= 1'b0;
    end else if (pause) begin
      w       <= IDLE_BIT;
      w_valid <= 1'b0;
      last    <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          w       <= shift_bit;
          w_valid <= 1'b1;
          last    <= (rem == CW'(1));
          shifter <= shift_next;
          rem     <= rem - CW'(1);
        end
        IDLE: begin
          if (hold_full) begin
            w       <= hold_bit;
            w_valid <= 1'b1;
            last    <= 1'b0;
            shifter <= hold_next;
            rem     <= CW'(WIDTH - 1);
          end else begin
            w       <= IDLE_BIT;
            w_valid <= 1'b0;
            last    <= 1'b0;
          end
        end
        default: begin
          w       <= IDLE_BIT;
          w_valid <= 1'b0;
          last    <= 1'b0;
        end
      endcase
    end
  end

endmodule
